dtack_generator: RTL and testbench

// Bus-cycle responder for the 68k local bus. Consumes the chip-select outputs of the

---
 rtl/dtack_generator_if.sv | 32 +++
 rtl/dtack_generator.sv | 147 ++++++++++++++
 tb/tb_dtack_generator.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtack_generator_if.sv
// 68k local-bus signals between the CPU/decoder side and the DTACK responder.
interface dtack_generator_if;
  logic AS_L;
  logic UDS_L;
  logic LDS_L;
  logic OnChipRomSelect_H;
  logic OnChipRamSelect_H;
  logic IOSelect_H;
  logic CanBusSelect_H;
  logic DramSelect_H;
  logic DramDtack_L;
  logic CanDtack_L;
  logic Dtack_L;
  logic BErr_L;
  logic Timeout_H;

  // CPU, decoder and external slaves
  modport master (
    output AS_L, UDS_L, LDS_L,
    output OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H, DramSelect_H,
    output DramDtack_L, CanDtack_L,
    input  Dtack_L, BErr_L, Timeout_H
  );

  // Bus-cycle responder
  modport slave (
    input  AS_L, UDS_L, LDS_L,
    input  OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H, DramSelect_H,
    input  DramDtack_L, CanDtack_L,
    output Dtack_L, BErr_L, Timeout_H
  );
endinterface

// File: rtl/dtack_generator.sv
// Bus-cycle terminator: fixed wait states for on-chip regions, slave DTACK
// pass-through for CAN/DRAM, bus error on timeout.
module dtack_generator #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input logic              Clk,
  input logic              Reset_H,
  dtack_generator_if.slave bus
);

  localparam int unsigned EW = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    REG_ROM  = 3'd1,
    REG_RAM  = 3'd2,
    REG_IO   = 3'd3,
    REG_CAN  = 3'd4,
    REG_DRAM = 3'd5
  } region_e;

  state_e           state_q, state_d;
  region_e          region_q, region_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dtack_l_q, berr_l_q, timeout_q;
  logic             timeout_d;

  logic             cycle_start_c;
  region_e          sel_region_c;
  logic             sel_zero_wait_c;
  logic [EW-1:0]    elapsed_c;
  logic             ack_now_c;

  // A cycle begins when the address strobe and at least one data strobe are low
  assign cycle_start_c = !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);

  // Wait edges seen so far including the current one
  assign elapsed_c = EW'(cnt_q) + EW'(1);

  // Fixed-priority region decode; RAM beats DRAM where the two overlap
  always_comb begin
    sel_region_c = REG_NONE;
    if (bus.OnChipRomSelect_H)      sel_region_c = REG_ROM;
    else if (bus.OnChipRamSelect_H) sel_region_c = REG_RAM;
    else if (bus.IOSelect_H)        sel_region_c = REG_IO;
    else if (bus.CanBusSelect_H)    sel_region_c = REG_CAN;
    else if (bus.DramSelect_H)      sel_region_c = REG_DRAM;
  end

  // Internal regions configured with no wait states acknowledge straight from IDLE
  always_comb begin
    sel_zero_wait_c = 1'b0;
    unique case (sel_region_c)
      REG_ROM: sel_zero_wait_c = (ROM_WAIT == 0);
      REG_RAM: sel_zero_wait_c = (RAM_WAIT == 0);
      REG_IO:  sel_zero_wait_c = (IO_WAIT == 0);
      default: sel_zero_wait_c = 1'b0;
    endcase
  end

  // Termination condition for the latched region on this edge
  always_comb begin
    ack_now_c = 1'b0;
    unique case (region_q)
      REG_ROM:  ack_now_c = (elapsed_c >= EW'(ROM_WAIT));
      REG_RAM:  ack_now_c = (elapsed_c >= EW'(RAM_WAIT));
      REG_IO:   ack_now_c = (elapsed_c >= EW'(IO_WAIT));
      REG_CAN:  ack_now_c = !bus.CanDtack_L;
      REG_DRAM: ack_now_c = !bus.DramDtack_L;
      default:  ack_now_c = 1'b0;
    endcase
  end

  // Next-state logic; slave DTACK takes precedence over a coincident timeout
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cycle_start_c) begin
          region_d = sel_region_c;
          state_d  = sel_zero_wait_c ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.AS_L) begin
          state_d  = ST_IDLE;
          region_d = REG_NONE;
          cnt_d    = '0;
        end else if (ack_now_c) begin
          state_d = ST_ACK;
        end else if (elapsed_c >= EW'(TIMEOUT)) begin
          state_d   = ST_BERR;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK, ST_BERR: begin
        if (bus.AS_L) begin
          state_d  = ST_IDLE;
          region_d = REG_NONE;
          cnt_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state_q   <= ST_IDLE;
      region_q  <= REG_NONE;
      cnt_q     <= '0;
      dtack_l_q <= 1'b1;
      berr_l_q  <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      cnt_q     <= cnt_d;
      dtack_l_q <= (state_d != ST_ACK);
      berr_l_q  <= (state_d != ST_BERR);
      timeout_q <= timeout_d;
    end
  end

  assign bus.Dtack_L   = dtack_l_q;
  assign bus.BErr_L    = berr_l_q;
  assign bus.Timeout_H = timeout_q;

endmodule

// File: tb/tb_dtack_generator.sv
// Directed bench for dtack_generator: wait states, slave DTACK, timeout, abort, reset.
module tb_dtack_generator;

  logic Clk;
  logic Reset_H;
  int   errors;
  int   checks;

  dtack_generator_if bus ();

  dtack_generator dut (
    .Clk     (Clk),
    .Reset_H (Reset_H),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to the next rising edge and settle
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.AS_L = 1'b1; bus.UDS_L = 1'b1; bus.LDS_L = 1'b1;
    bus.OnChipRomSelect_H = 1'b0; bus.OnChipRamSelect_H = 1'b0;
    bus.IOSelect_H = 1'b0; bus.CanBusSelect_H = 1'b0; bus.DramSelect_H = 1'b0;
    bus.DramDtack_L = 1'b1; bus.CanDtack_L = 1'b1;
  endtask

  // DTACK and BERR must never be asserted together
  always @(negedge Clk) begin
    if (!Reset_H) begin
      checks++;
      if (!bus.Dtack_L && !bus.BErr_L) begin
        errors++;
        $display("FAIL exclusive: Dtack_L=%b BErr_L=%b, required not both 0 at %0t",
                 bus.Dtack_L, bus.BErr_L, $time);
      end
    end
  end

  task automatic test_reset();
    bus_idle();
    Reset_H = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.Dtack_L, bus.BErr_L, bus.Timeout_H} !== 3'b110) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 110", {bus.Dtack_L, bus.BErr_L, bus.Timeout_H});
    end
    #3 Reset_H = 1'b0;
    tick();
    checks++;
    if ({bus.Dtack_L, bus.BErr_L, bus.Timeout_H} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required 110", {bus.Dtack_L, bus.BErr_L, bus.Timeout_H});
    end
  endtask

  task automatic test_rom_read();
    bus.AS_L = 1'b0; bus.UDS_L = 1'b0; bus.OnChipRomSelect_H = 1'b1;
    tick(); // E0
    checks++;
    if (bus.Dtack_L !== 1'b1) begin
      errors++; $display("FAIL rom_e0: Dtack_L=%b required 1", bus.Dtack_L);
    end
    tick(); // E0+1
    checks++;
    if (bus.Dtack_L !== 1'b0) begin
      errors++; $display("FAIL rom_e1: Dtack_L=%b required 0", bus.Dtack_L);
    end
    tick(); tick(); tick(); // E0+4
    checks++;
    if ({bus.Dtack_L, bus.BErr_L} !== 2'b01) begin
      errors++; $display("FAIL rom_hold: Dtack_L,BErr_L=%b required 01", {bus.Dtack_L, bus.BErr_L});
    end
    bus_idle();
    tick(); // E0+5
    checks++;
    if (bus.Dtack_L !== 1'b1) begin
      errors++; $display("FAIL rom_release: Dtack_L=%b required 1", bus.Dtack_L);
    end
    tick();
  endtask

  task automatic test_io_reset();
    bus.AS_L = 1'b0; bus.LDS_L = 1'b0; bus.IOSelect_H = 1'b1;
    tick(); // E0
    bus.OnChipRomSelect_H = 1'b1; // late select must be ignored
    tick(); // E0+1
    checks++;
    if (bus.Dtack_L !== 1'b1) begin
      errors++; $display("FAIL io_e1_late_sel: Dtack_L=%b required 1", bus.Dtack_L);
    end
    tick(); // E0+2
    checks++;
    if (bus.Dtack_L !== 1'b0) begin
      errors++; $display("FAIL io_e2: Dtack_L=%b required 0", bus.Dtack_L);
    end
    #3 Reset_H = 1'b1;
    #1;
    checks++;
    if ({bus.Dtack_L, bus.BErr_L, bus.Timeout_H} !== 3'b110) begin
      errors++; $display("FAIL io_async_reset: got %b required 110", {bus.Dtack_L, bus.BErr_L, bus.Timeout_H});
    end
    tick();
    bus.OnChipRomSelect_H = 1'b0;
    #2 Reset_H = 1'b0;
    tick(); // new E0: IDLE sees the still-active IO cycle
    tick();
    checks++;
    if (bus.Dtack_L !== 1'b1) begin
      errors++; $display("FAIL io_restart_e1: Dtack_L=%b required 1", bus.Dtack_L);
    end
    tick();
    checks++;
    if (bus.Dtack_L !== 1'b0) begin
      errors++; $display("FAIL io_restart_e2: Dtack_L=%b required 0", bus.Dtack_L);
    end
    bus_idle();
    tick(); tick();
  endtask

  task automatic test_dram();
    bit early;
    early = 1'b0;
    bus.AS_L = 1'b0; bus.UDS_L = 1'b0; bus.LDS_L = 1'b0; bus.DramSelect_H = 1'b1;
    bus.CanDtack_L = 1'b0;
    tick(); // E0
    for (int k = 1; k <= 5; k++) begin
      bus.CanDtack_L = ~bus.CanDtack_L;
      tick();
      if (bus.Dtack_L !== 1'b1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL dram_wait: early Dtack_L seen=%b required 0", early);
    end
    bus.DramDtack_L = 1'b0;
    bus.CanDtack_L = ~bus.CanDtack_L;
    tick(); // E0+6
    checks++;
    if (bus.Dtack_L !== 1'b0) begin
      errors++; $display("FAIL dram_ack: Dtack_L=%b required 0", bus.Dtack_L);
    end
    bus_idle();
    tick();
    checks++;
    if (bus.Dtack_L !== 1'b1) begin
      errors++; $display("FAIL dram_release: Dtack_L=%b required 1", bus.Dtack_L);
    end
    tick();
  endtask

  task automatic test_can();
    bus.AS_L = 1'b0; bus.UDS_L = 1'b0; bus.CanBusSelect_H = 1'b1;
    bus.DramDtack_L = 1'b0; // other slave must be ignored
    tick(); // E0
    tick(); tick(); // E0+2
    checks++;
    if (bus.Dtack_L !== 1'b1) begin
      errors++; $display("FAIL can_wait: Dtack_L=%b required 1", bus.Dtack_L);
    end
    bus.CanDtack_L = 1'b0;
    tick(); // E0+3
    checks++;
    if (bus.Dtack_L !== 1'b0) begin
      errors++; $display("FAIL can_ack: Dtack_L=%b required 0", bus.Dtack_L);
    end
    bus_idle();
    tick(); tick();
  endtask

  task automatic test_timeout();
    bit bad;
    int pulses;
    bad = 1'b0;
    pulses = 0;
    bus.AS_L = 1'b0; bus.UDS_L = 1'b0;
    tick(); // E0
    for (int k = 1; k <= 254; k++) begin
      tick();
      if ({bus.Dtack_L, bus.BErr_L, bus.Timeout_H} !== 3'b110) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL timeout_early: premature output seen=%b required 0", bad);
    end
    tick(); // E0+255
    checks++;
    if ({bus.Dtack_L, bus.BErr_L, bus.Timeout_H} !== 3'b101) begin
      errors++; $display("FAIL timeout_berr: got %b required 101", {bus.Dtack_L, bus.BErr_L, bus.Timeout_H});
    end
    pulses = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.Timeout_H === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL timeout_pulse_count: got %0d required 1", pulses);
    end
    checks++;
    if ({bus.Dtack_L, bus.BErr_L} !== 2'b10) begin
      errors++; $display("FAIL timeout_hold: got %b required 10", {bus.Dtack_L, bus.BErr_L});
    end
    bus_idle();
    tick();
    checks++;
    if (bus.BErr_L !== 1'b1) begin
      errors++; $display("FAIL timeout_release: BErr_L=%b required 1", bus.BErr_L);
    end
    tick();
  endtask

  task automatic test_ram_dram_overlap();
    bus.AS_L = 1'b0; bus.UDS_L = 1'b0;
    bus.OnChipRamSelect_H = 1'b1; bus.DramSelect_H = 1'b1;
    tick(); // E0
    tick(); // E0+1
    checks++;
    if (bus.Dtack_L !== 1'b0) begin
      errors++; $display("FAIL overlap_ack: Dtack_L=%b required 0", bus.Dtack_L);
    end
    for (int k = 0; k < 300; k++) tick();
    checks++;
    if ({bus.Dtack_L, bus.BErr_L} !== 2'b01) begin
      errors++; $display("FAIL overlap_no_berr: got %b required 01", {bus.Dtack_L, bus.BErr_L});
    end
    bus_idle();
    tick(); tick();
  endtask

  task automatic test_abort_and_edge();
    bit bad;
    bad = 1'b0;
    bus.AS_L = 1'b0; bus.UDS_L = 1'b0; bus.DramSelect_H = 1'b1;
    tick(); // E0
    tick(); // E0+1
    bus_idle();
    tick(); // E0+2 samples AS_L high
    for (int k = 0; k < 4; k++) begin
      if ({bus.Dtack_L, bus.BErr_L, bus.Timeout_H} !== 3'b110) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: output seen=%b required 0", bad);
    end
    bus.AS_L = 1'b0; bus.UDS_L = 1'b0; bus.OnChipRomSelect_H = 1'b1;
    tick(); tick();
    checks++;
    if (bus.Dtack_L !== 1'b0) begin
      errors++; $display("FAIL abort_next_rom: Dtack_L=%b required 0", bus.Dtack_L);
    end
    bus_idle();
    tick(); tick();
    // DRAM DTACK on the very edge that would otherwise time out
    bus.AS_L = 1'b0; bus.LDS_L = 1'b0; bus.DramSelect_H = 1'b1;
    tick(); // E0
    for (int k = 1; k <= 254; k++) tick();
    checks++;
    if ({bus.Dtack_L, bus.BErr_L} !== 2'b11) begin
      errors++; $display("FAIL edge_e254: got %b required 11", {bus.Dtack_L, bus.BErr_L});
    end
    bus.DramDtack_L = 1'b0;
    tick(); // E0+255
    checks++;
    if ({bus.Dtack_L, bus.BErr_L, bus.Timeout_H} !== 3'b010) begin
      errors++; $display("FAIL edge_dtack_wins: got %b required 010", {bus.Dtack_L, bus.BErr_L, bus.Timeout_H});
    end
    bus_idle();
    tick(); tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset_H = 1'b1;
    test_reset();
    test_rom_read();
    test_io_reset();
    test_dram();
    test_can();
    test_timeout();
    test_ram_dram_overlap();
    test_abort_and_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
